shifter_pipe: RTL
=================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width; legal values are powers of 2, at least 8.
REQ-002 The block SHALL have parameter STEP, default 4, meaning the maximum bit positions shifted per BUSY cycle; legal values are powers of 2, at most WIDTH/2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port A, input, WIDTH bits: the shift amount is A[SW-1:0], where SW = log2(WIDTH); upper bits are ignored.
REQ-008 The block SHALL have port B, input, WIDTH bits: the operand to shift.
REQ-009 The block SHALL have port aluc, input, 3 bits: the mode select.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port Result, output, WIDTH bits: the shifted value.
REQ-013 The block SHALL have ports Zero, Carry, Negative and Overflow, each output, 1 bit: the status flags.

Function
REQ-014 The block SHALL decode aluc as follows:
- 000: SRA
- 001: SRL
- 010: SLL
- 011: SLA (left shift with overflow check)
- 100: ROR
- 101: ROL
- 110 and 111: reserved, pass-through.
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Acceptance SHALL occur when in_valid && in_ready at a rising edge; at acceptance B, amount and mode are captured, remaining = amount, Carry/Overflow accumulators clear, and the FSM moves IDLE->BUSY.
REQ-017 In BUSY the block SHALL, each cycle, shift or rotate the working register by k = min(remaining, STEP) positions and set remaining -= k.
REQ-018 Cycles spent in BUSY SHALL be max(1, ceil(amount/STEP)); after the final BUSY cycle the FSM moves to DONE.
REQ-019 For amount 0 and for reserved modes, the single BUSY cycle SHALL leave the value unchanged.
REQ-020 In DONE, Result and the flags SHALL be held stable until out_ready = 1; then the FSM moves DONE->IDLE; no new request is accepted in that same cycle.
REQ-021 Inputs SHALL be ignored outside IDLE, and in_valid without in_ready SHALL have no effect.
REQ-022 Arithmetic and rotate rules:
- SRA SHALL replicate B[WIDTH-1].
- SRL and SLL/SLA SHALL fill with 0.
- Rotates SHALL be modulo WIDTH.
REQ-023 Carry SHALL be defined as follows:
- Amount 0 or reserved mode: Carry = 0.
- SRA/SRL: Carry = B[amount-1].
- SLL/SLA: Carry = B[WIDTH-amount].
- ROR: Carry = Result[WIDTH-1].
- ROL: Carry = Result[0].
REQ-024 Overflow SHALL be 1 only in SLA when bits B[WIDTH-1 : WIDTH-1-amount] are not all equal (a sign change during the shift); otherwise Overflow = 0.
REQ-025 Zero SHALL be (Result == 0), and Negative SHALL be Result[WIDTH-1], for all modes, including pass-through.
REQ-026 Outputs SHALL be registered; no combinational path SHALL exist from inputs to Result or flags.

Reset
REQ-027 While rst_n = 0 the block SHALL immediately (asynchronously) enter IDLE, with in_ready = 1, out_valid = 0, Result = 0, Zero = 0, Carry = 0, Negative = 0 and Overflow = 0.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation; no result is emitted for it after reset release.
REQ-029 The first acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Verification (WIDTH=32, STEP=4)
REQ-030 The bench SHALL cover SRA: aluc=000, B=0x80000000, A=4 -> Result 0xF8000000, Carry 0, Negative 1, Zero 0, exactly 1 BUSY cycle.
REQ-031 The bench SHALL cover SRL at maximum amount: aluc=001, B=0x80000001, A=31 -> Result 0x00000001, Carry 0, 8 BUSY cycles; in_ready low throughout.
REQ-032 The bench SHALL cover SLA overflow: aluc=011, B=0x40000000, A=1 -> Result 0x80000000, Overflow 1, Carry 0, Negative 1.
REQ-033 The bench SHALL cover ROL with amount 0:
- aluc=101, B=0x80000001, A=4 -> Result 0x00000018, Carry 0.
- Same operands, A=0 -> Result 0x80000001, Carry 0.
REQ-034 The bench SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> Result and flags stable, in_ready 0; out_ready=1 -> IDLE on the next edge.
REQ-035 The bench SHALL cover reset mid-operation: rst_n pulsed low during BUSY of an A=31 request -> outputs at reset values immediately, no out_valid afterwards; a new request then completes correctly.

Source files
------------

// File: rtl/shifter_pipe.sv
// Multi-cycle shifter/rotator with valid/ready handshakes on both sides.
// An accepted request is shifted at most STEP positions per BUSY cycle.
// The registered result and flags stay stable in DONE until the consumer
// takes them.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    localparam int             SW     = $clog2(WIDTH);
    localparam logic [SW-1:0]  STEP_V = SW'(STEP);

    localparam logic [2:0] M_SRA = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SLL = 3'b010;
    localparam logic [2:0] M_SLA = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;
    localparam logic [2:0] M_ROL = 3'b101;

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SW-1:0]    rem;
    logic [2:0]       mode;
    logic             c_acc;
    logic             v_acc;
    logic             amt_nz;

    logic [SW-1:0]    k;
    logic             last;
    logic [WIDTH-1:0] nxt_work;
    logic             nxt_c;
    logic             nxt_v;
    logic             fin_c;
    logic             r_out;
    logic             l_out;
    logic [WIDTH-1:0] sla_sh;
    logic [WIDTH-1:0] sla_back;

    // Only the low SW bits of A select the amount.
    logic unused_a;
    assign unused_a = ^A[WIDTH-1:SW];

    // One step of the datapath: shift by k = min(rem, STEP), track the last
    // bit shifted out and whether the top k+1 bits disagreed (SLA sign change).
    always_comb begin
        k        = (rem < STEP_V) ? rem : STEP_V;
        last     = (rem <= STEP_V);
        nxt_work = work;
        nxt_c    = c_acc;
        nxt_v    = v_acc;
        // last bit leaving on the right is work[k-1], on the left work[WIDTH-k]
        r_out    = |(work & (LSB_ONE << (k - 1'b1)));
        l_out    = |(work & (MSB_ONE >> (k - 1'b1)));
        // top k+1 bits all equal  <=>  (work << k) >>> k reproduces work
        sla_sh   = work << k;
        sla_back = $signed(sla_sh) >>> k;
        case (mode)
            M_SRA: begin
                nxt_work = $signed(work) >>> k;
                if (k != '0) nxt_c = r_out;
            end
            M_SRL: begin
                nxt_work = work >> k;
                if (k != '0) nxt_c = r_out;
            end
            M_SLL: begin
                nxt_work = work << k;
                if (k != '0) nxt_c = l_out;
            end
            M_SLA: begin
                nxt_work = work << k;
                if (k != '0) nxt_c = l_out;
                if (sla_back != work) nxt_v = 1'b1;
            end
            M_ROR: nxt_work = (work >> k) | (work << (WIDTH - int'(k)));
            M_ROL: nxt_work = (work << k) | (work >> (WIDTH - int'(k)));
            default: ;
        endcase
        // rotate carry is read from the final value, and only for a nonzero amount
        case (mode)
            M_ROR:   fin_c = amt_nz & nxt_work[WIDTH-1];
            M_ROL:   fin_c = amt_nz & nxt_work[0];
            default: fin_c = nxt_c;
        endcase
    end

    // Control FSM plus working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Carry     <= 1'b0;
            Negative  <= 1'b0;
            Overflow  <= 1'b0;
            work      <= '0;
            rem       <= '0;
            mode      <= '0;
            c_acc     <= 1'b0;
            v_acc     <= 1'b0;
            amt_nz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= B;
                        rem      <= A[SW-1:0];
                        mode     <= aluc;
                        amt_nz   <= |A[SW-1:0];
                        c_acc    <= 1'b0;
                        v_acc    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work  <= nxt_work;
                    rem   <= rem - k;
                    c_acc <= nxt_c;
                    v_acc <= nxt_v;
                    if (last) begin
                        Result    <= nxt_work;
                        Zero      <= (nxt_work == '0);
                        Negative  <= nxt_work[WIDTH-1];
                        Carry     <= fin_c;
                        Overflow  <= nxt_v;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
